// File: rtl/axis_log2lin_if.sv
// AXI-Stream item bus: one data word, end-of-packet flag and a valid/ready pair.
// A transfer happens on a rising clock edge where tvalid and tready are both high.
interface axis_log2lin_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_log2lin.sv
// Log2-power to linear-power converter: P = 2^(L / 2^FRAC_W), saturating at 2^OUT_W-1.
// Three-stage pipeline (LUT, shift, saturate) streaming one item per clock.
module axis_log2lin #(
    parameter int LOG_W  = 16,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    axis_log2lin_if.slave  s_axis,
    axis_log2lin_if.master m_axis
);
    localparam int INT_W = LOG_W - FRAC_W;
    localparam int LUT_D = 1 << FRAC_W;

    // Mantissa table: round(2^15 * 2^(f / 2^FRAC_W)), evaluated at elaboration.
    function automatic logic [15:0] lut_val(input int f);
        real m;
        m = 32768.0 * (2.0 ** (real'(f) / real'(LUT_D)));
        return 16'($rtoi(m + 0.5));
    endfunction

    logic [15:0] lut [LUT_D];
    for (genvar g = 0; g < LUT_D; g++) begin : g_lut
        localparam logic [15:0] MANT = lut_val(g);
        assign lut[g] = MANT;
    end

    logic             rdy_q;
    logic             v1_q, l1_q;
    logic [INT_W-1:0] i1_q;
    logic [15:0]      m1_q;
    logic             v2_q, l2_q, sat2_q;
    logic [OUT_W-1:0] p2_q;
    logic             v3_q, l3_q;
    logic [OUT_W-1:0] d3_q;

    logic             en1, en2, en3, s_fire;
    logic [INT_W-1:0] i1_d;
    logic [15:0]      m1_d;
    logic             sat2_d;
    logic [OUT_W-1:0] p2_d, d3_d;

    // A stage may load when it is empty or its content moves on this cycle;
    // the ready chain runs backwards from m_axis.tready only.
    assign en3 = !v3_q || m_axis.tready;
    assign en2 = !v2_q || en3;
    assign en1 = !v1_q || en2;
    assign s_axis.tready = rdy_q && en1;
    assign s_fire        = s_axis.tvalid && s_axis.tready;

    assign i1_d   = s_axis.tdata[LOG_W-1:FRAC_W];
    assign m1_d   = lut[s_axis.tdata[FRAC_W-1:0]];
    assign sat2_d = int'(i1_q) >= OUT_W;
    assign p2_d   = OUT_W'(({{OUT_W{1'b0}}, m1_q} << i1_q) >> 15);
    assign d3_d   = sat2_q ? '1 : p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
            i1_q   <= '0;
            m1_q   <= '0;
            v2_q   <= 1'b0;
            l2_q   <= 1'b0;
            sat2_q <= 1'b0;
            p2_q   <= '0;
            v3_q   <= 1'b0;
            l3_q   <= 1'b0;
            d3_q   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (en1) begin
                v1_q <= s_fire;
                l1_q <= s_axis.tlast;
                i1_q <= i1_d;
                m1_q <= m1_d;
            end
            if (en2) begin
                v2_q   <= v1_q;
                l2_q   <= l1_q;
                sat2_q <= sat2_d;
                p2_q   <= p2_d;
            end
            if (en3) begin
                v3_q <= v2_q;
                l3_q <= l2_q;
                d3_q <= d3_d;
            end
        end
    end

    assign m_axis.tvalid = v3_q;
    assign m_axis.tdata  = d3_q;
    assign m_axis.tlast  = l3_q;
endmodule

// File: tb/tb_axis_log2lin.sv
// Bench for axis_log2lin: directed conversions, random streaming against an
// arithmetic model, backpressure fill/release and asynchronous reset mid-packet.
module tb_axis_log2lin;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axis_log2lin_if #(.DATA_W(16)) s_if ();
    axis_log2lin_if #(.DATA_W(32)) m_if ();

    logic rand_ready = 1'b0;
    logic m_ready_rand = 1'b0;
    logic m_ready_dir = 1'b0;
    assign m_if.tready = rand_ready ? m_ready_rand : m_ready_dir;

    axis_log2lin #(.LOG_W(16), .FRAC_W(8), .OUT_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    logic [32:0] exp_q[$];
    logic        pend = 1'b0;

    // P = floor(round(2^15 * 2^(F/256)) * 2^I / 2^15), all ones once I >= 32
    function automatic logic [31:0] model_p(input logic [15:0] l);
        int     i, f;
        longint mant, p;
        i = int'(l[15:8]);
        f = int'(l[7:0]);
        if (i >= 32) return 32'hFFFF_FFFF;
        mant = longint'($rtoi(32768.0 * (2.0 ** (real'(f) / 256.0)) + 0.5));
        p = (mant * (longint'(1) << i)) / 32768;
        return p[31:0];
    endfunction

    function automatic logic [15:0] rand_l();
        if ($urandom_range(0, 3) != 0) return 16'($urandom_range(0, 16'h1FFF));
        return 16'($urandom_range(0, 16'hFFFF));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        m_ready_rand = ($urandom_range(0, 1) == 1);
    end

    // Compare process: inputs settle at posedge+2, everything is observed at negedge.
    logic        stall_pending = 1'b0;
    logic [31:0] held_d;
    logic        held_l;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pending = 1'b0;
        end else begin
            if (s_if.tvalid && s_if.tready)
                exp_q.push_back({s_if.tlast, model_p(s_if.tdata)});
            if (stall_pending)
                chk("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, held_l, held_d});
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got %0h expected no item", m_if.tdata);
                end else begin
                    chk("out_item", {m_if.tlast, m_if.tdata}, exp_q.pop_front());
                end
            end
            stall_pending = m_if.tvalid && !m_if.tready;
            held_d = m_if.tdata;
            held_l = m_if.tlast;
        end
    end

    // Enters and returns at posedge+2; offers one item and records what the edge saw.
    task automatic stream_step(input logic want_valid, output logic acc,
                               output logic mv, output logic sr);
        if (!pend) begin
            s_if.tvalid = want_valid;
            s_if.tdata  = rand_l();
            s_if.tlast  = ($urandom_range(0, 7) == 0);
        end
        #1;
        acc = s_if.tvalid && s_if.tready;
        mv  = m_if.tvalid;
        sr  = s_if.tready;
        @(posedge clk);
        #2;
        pend = s_if.tvalid && !acc;
    endtask

    task automatic send_one(input logic [15:0] l, input logic last, input logic [31:0] exp);
        int   lat;
        int   tries;
        logic acc;
        s_if.tdata  = l;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            #1;
            acc = s_if.tready;
            @(posedge clk);
            #2;
            tries++;
        end
        s_if.tvalid = 1'b0;
        chk("accept_timeout", 64'(acc), 64'(1));
        lat = 1;
        while (!m_if.tvalid && lat < 10) begin
            @(posedge clk);
            #2;
            lat++;
        end
        chk("latency", 64'(lat), 64'(3));
        chk("direct_data", 64'(m_if.tdata), 64'(exp));
        chk("direct_last", 64'(m_if.tlast), 64'(last));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic acc, mv, sr;
        int   cnt, seen, sent;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        chk("rst_m_valid", 64'(m_if.tvalid), 64'(0));
        chk("rst_m_data", 64'(m_if.tdata), 64'(0));
        chk("rst_m_last", 64'(m_if.tlast), 64'(0));
        chk("rst_s_ready", 64'(s_if.tready), 64'(0));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("ready_after_rst", 64'(s_if.tready), 64'(1));

        chk("model_0000", 64'(model_p(16'h0000)), 64'(1));
        chk("model_0080", 64'(model_p(16'h0080)), 64'(1));
        chk("model_0880", 64'(model_p(16'h0880)), 64'(362));
        chk("model_1fff", 64'(model_p(16'h1FFF)), 64'(32'hFF4F_0000));
        chk("model_2000", 64'(model_p(16'h2000)), 64'(32'hFFFF_FFFF));

        m_ready_dir = 1'b1;
        send_one(16'h0000, 1'b0, 32'h0000_0001);
        send_one(16'h0080, 1'b1, 32'h0000_0001);
        send_one(16'h0800, 1'b0, 32'd256);
        send_one(16'h0880, 1'b0, 32'd362);
        send_one(16'h1FFF, 1'b1, 32'hFF4F_0000);
        send_one(16'h2000, 1'b0, 32'hFFFF_FFFF);
        send_one(16'hFFFF, 1'b1, 32'hFFFF_FFFF);
        drain();

        rand_ready = 1'b1;
        sent = 0;
        while (sent < 1000) begin
            stream_step($urandom_range(0, 1) == 1, acc, mv, sr);
            if (acc) sent++;
        end
        s_if.tvalid = 1'b0;
        pend = 1'b0;
        rand_ready = 1'b0;
        m_ready_dir = 1'b1;
        drain();

        m_ready_dir = 1'b0;
        cnt = 0;
        repeat (6) begin
            stream_step(1'b1, acc, mv, sr);
            if (acc) cnt++;
        end
        chk("fill_accepts", 64'(cnt), 64'(3));
        chk("fill_ready_low", 64'(s_if.tready), 64'(0));
        m_ready_dir = 1'b1;
        repeat (6) begin
            stream_step(1'b1, acc, mv, sr);
            chk("release_m_valid", 64'(mv), 64'(1));
            chk("release_s_ready", 64'(sr), 64'(1));
        end
        s_if.tvalid = 1'b0;
        pend = 1'b0;
        drain();

        m_ready_dir = 1'b0;
        repeat (3) begin
            stream_step(1'b1, acc, mv, sr);
            chk("pkt_accept", 64'(acc), 64'(1));
        end
        s_if.tvalid = 1'b0;
        pend = 1'b0;
        chk("pre_rst_valid", 64'(m_if.tvalid), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_m_valid", 64'(m_if.tvalid), 64'(0));
        chk("async_m_data", 64'(m_if.tdata), 64'(0));
        chk("async_s_ready", 64'(s_if.tready), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_ready_dir = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #2;
            if (m_if.tvalid) seen++;
        end
        chk("no_stale_item", 64'(seen), 64'(0));
        send_one(16'h0880, 1'b1, 32'd362);
        send_one(16'h0800, 1'b0, 32'd256);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
